// File: rtl/iter_divider_if.sv
// iter_divider_if: operand/result bundle for the iterative divider.
//   start      request a new division (master -> slave)
//   is_signed  1 = DIV (two's complement), 0 = DIVU
//   dividend   numerator
//   divisor    denominator
//   quotient   registered quotient (slave -> master), feeds LO
//   remainder  registered remainder (slave -> master), feeds HI
//   busy       operation in progress
//   done       one-cycle completion pulse
//   div_zero   last completed operation had divisor == 0
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  quotient, remainder, busy, done, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output quotient, remainder, busy, done, div_zero
    );
endinterface

// File: rtl/iter_divider.sv
// iter_divider: multi-cycle non-restoring integer divider (DIV/DIVU).
// One quotient bit per clock; all state changes on the falling edge of clk.
// Ports:
//   clk    clock (falling-edge active)
//   reset  asynchronous, active-high
//   bus    iter_divider_if slave: start/is_signed/dividend/divisor in,
//          quotient/remainder/busy/done/div_zero out
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one non-restoring step per edge, WIDTH edges
// FIX   | remainder restore, sign correction, results registered, done
module iter_divider #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    iter_divider_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q,     state_d;
    logic [WIDTH:0]     rem_q,       rem_d;       // signed partial remainder
    logic [WIDTH-1:0]   work_q,      work_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   dvs_q,       dvs_d;       // divisor magnitude
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               q_neg_q,     q_neg_d;
    logic               r_neg_q,     r_neg_d;
    logic               zero_q,      zero_d;
    logic [WIDTH-1:0]   quotient_q,  quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               done_q,      done_d;
    logic               div_zero_q,  div_zero_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     step;
    logic [WIDTH-1:0]   rem_mag;

    // The shifted value can exceed the WIDTH+1-bit signed range, but the
    // result after add/subtract always lies in (-divisor, divisor), so the
    // modular WIDTH+1-bit arithmetic still lands on the right value.
    assign shifted = {rem_q[WIDTH-1:0], work_q[WIDTH-1]};
    assign step    = rem_q[WIDTH] ? (shifted + {1'b0, dvs_q})
                                  : (shifted - {1'b0, dvs_q});

    // The true remainder lies in [0, divisor), so WIDTH bits suffice for the restore.
    assign rem_mag = rem_q[WIDTH-1:0] + (rem_q[WIDTH] ? dvs_q : '0);

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        div_zero_d  = div_zero_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    q_neg_d = bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                    r_neg_d = bus.is_signed & bus.dividend[WIDTH-1];
                    if (bus.divisor == '0) begin
                        // keep the raw dividend: it is returned untouched as the remainder
                        zero_d  = 1'b1;
                        work_d  = bus.dividend;
                        state_d = FIX;
                    end else begin
                        zero_d  = 1'b0;
                        work_d  = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend
                                                                           : bus.dividend;
                        dvs_d   = (bus.is_signed && bus.divisor[WIDTH-1]) ? -bus.divisor
                                                                          : bus.divisor;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                rem_d  = step;
                work_d = {work_q[WIDTH-2:0], ~step[WIDTH]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = work_q;
                    div_zero_d  = 1'b1;
                end else begin
                    quotient_d  = q_neg_q ? -work_q  : work_q;
                    remainder_d = r_neg_q ? -rem_mag : rem_mag;
                    div_zero_d  = 1'b0;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            work_q      <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;

endmodule
